// File: rtl/switch_debounce_pair.sv
// ---------------------------------------------------------------------------
// switch_debounce_pair
//
// Two-channel switch/button conditioner. Each raw board pin is brought into
// the clk domain through a flop-chain synchronizer and then filtered by a
// counter-based debounce FSM. The result is a clean level that drives one
// operand of the downstream AND gate, plus one-cycle rise and fall strobes.
//
// Parameters
//   DEBOUNCE_CYCLES : number of consecutive synchronized samples that must
//                     differ from the current level before the level follows
//                     (>= 1).
//   SYNC_STAGES     : synchronizer depth per channel (>= 2).
//
// Ports
//   clk             : system clock, rising edge
//   rst             : synchronous, active-high reset
//   raw_1, raw_2    : asynchronous switch pins
//   input_1/input_2 : debounced levels (AND gate operands)
//   rise_1/rise_2   : one-cycle strobe on a 0->1 change of the level
//   fall_1/fall_2   : one-cycle strobe on a 1->0 change of the level
//   busy            : high while either channel is checking a candidate change
// ---------------------------------------------------------------------------
module switch_debounce_pair #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_1,
  input  logic raw_2,
  output logic input_1,
  output logic input_2,
  output logic rise_1,
  output logic fall_1,
  output logic rise_2,
  output logic fall_2,
  output logic busy
);

  logic checking_1;
  logic checking_2;

  switch_debounce_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_chan_1 (
    .clk      (clk),
    .rst      (rst),
    .raw      (raw_1),
    .level    (input_1),
    .rise     (rise_1),
    .fall     (fall_1),
    .checking (checking_1)
  );

  switch_debounce_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_chan_2 (
    .clk      (clk),
    .rst      (rst),
    .raw      (raw_2),
    .level    (input_2),
    .rise     (rise_2),
    .fall     (fall_2),
    .checking (checking_2)
  );

  // Both flags are flop outputs, so busy is a glitch-free OR of registered
  // state and lines up with the edge on which a channel enters CHECK.
  assign busy = checking_1 | checking_2;

endmodule

// ---------------------------------------------------------------------------
// switch_debounce_chan
//
// One conditioning channel: synchronizer followed by the debounce FSM.
//
// Ports
//   clk, rst  : clock and synchronous active-high reset
//   raw       : asynchronous switch pin
//   level     : debounced level (registered)
//   rise/fall : one-cycle strobes, asserted on the edge level changes
//   checking  : registered, high while in CHECK_HIGH or CHECK_LOW
// ---------------------------------------------------------------------------
module switch_debounce_chan #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic checking
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // With a single required sample there is nothing to count: the first
  // differing sample commits the new level directly.
  localparam bit DIRECT = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    STABLE_LOW,
    CHECK_HIGH,
    STABLE_HIGH,
    CHECK_LOW
  } state_t;

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   sync;
  state_t                 state;
  logic [CNT_W-1:0]       count;

  // ---- synchronizer stages: raw -> sync_p[0] ... sync_p[SYNC_STAGES-1] ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync = sync_p[SYNC_STAGES-1];

  // ---- debounce FSM: sync -> level / strobes / checking ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= STABLE_LOW;
      count    <= '0;
      level    <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      checking <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (sync) begin
            if (DIRECT) begin
              state    <= STABLE_HIGH;
              count    <= '0;
              level    <= 1'b1;
              rise     <= 1'b1;
              checking <= 1'b0;
            end else begin
              // The sample that triggered the check already counts as one.
              state    <= CHECK_HIGH;
              count    <= CNT_ONE;
              checking <= 1'b1;
            end
          end else begin
            checking <= 1'b0;
          end
        end

        CHECK_HIGH: begin
          if (!sync) begin
            // Bounce: candidate change rejected.
            state    <= STABLE_LOW;
            count    <= '0;
            checking <= 1'b0;
          end else if (count == CNT_LAST) begin
            state    <= STABLE_HIGH;
            count    <= '0;
            level    <= 1'b1;
            rise     <= 1'b1;
            checking <= 1'b0;
          end else begin
            count    <= count + CNT_ONE;
            checking <= 1'b1;
          end
        end

        STABLE_HIGH: begin
          if (!sync) begin
            if (DIRECT) begin
              state    <= STABLE_LOW;
              count    <= '0;
              level    <= 1'b0;
              fall     <= 1'b1;
              checking <= 1'b0;
            end else begin
              state    <= CHECK_LOW;
              count    <= CNT_ONE;
              checking <= 1'b1;
            end
          end else begin
            checking <= 1'b0;
          end
        end

        CHECK_LOW: begin
          if (sync) begin
            state    <= STABLE_HIGH;
            count    <= '0;
            checking <= 1'b0;
          end else if (count == CNT_LAST) begin
            state    <= STABLE_LOW;
            count    <= '0;
            level    <= 1'b0;
            fall     <= 1'b1;
            checking <= 1'b0;
          end else begin
            count    <= count + CNT_ONE;
            checking <= 1'b1;
          end
        end

        default: begin
          state    <= STABLE_LOW;
          count    <= '0;
          level    <= 1'b0;
          checking <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_debounce_pair.sv
module tb_switch_debounce_pair;

  logic clk;
  logic rst;
  logic raw_1;
  logic raw_2;
  logic input_1;
  logic input_2;
  logic rise_1;
  logic fall_1;
  logic rise_2;
  logic fall_2;
  logic busy;

  int checks;
  int errors;

  switch_debounce_pair #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .raw_1   (raw_1),
    .raw_2   (raw_2),
    .input_1 (input_1),
    .input_2 (input_2),
    .rise_1  (rise_1),
    .fall_1  (fall_1),
    .rise_2  (rise_2),
    .fall_2  (fall_2),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge. After the
  // k-th step following a change, the DUT has seen edges E .. E+k-1.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    raw_1 = 1'b0;
    raw_2 = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    rst   = 1'b1;
    raw_1 = 1'b1;
    raw_2 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      obs = {input_1, input_2, rise_1, fall_1, rise_2, fall_2, busy};
      checks++;
      if (obs !== 7'b0) begin
        errors++;
        $display("FAIL reset_outputs edge %0d: got %b want 0000000", k, obs);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (input_1 !== (k >= 6)) begin
        errors++;
        $display("FAIL reset_release_input_1 E+%0d: got %b want %b", k - 1, input_1, (k >= 6));
      end
      checks++;
      if (rise_1 !== (k == 6)) begin
        errors++;
        $display("FAIL reset_release_rise_1 E+%0d: got %b want %b", k - 1, rise_1, (k == 6));
      end
    end
  endtask

  task automatic test_clean_rise();
    apply_reset();
    raw_1 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (input_1 !== (k >= 6)) begin
        errors++;
        $display("FAIL clean_input_1 E+%0d: got %b want %b", k - 1, input_1, (k >= 6));
      end
      checks++;
      if (rise_1 !== (k == 6)) begin
        errors++;
        $display("FAIL clean_rise_1 E+%0d: got %b want %b", k - 1, rise_1, (k == 6));
      end
      if (k <= 5 || k == 7) begin
        checks++;
        if (busy !== (k >= 3 && k <= 5)) begin
          errors++;
          $display("FAIL clean_busy E+%0d: got %b want %b", k - 1, busy, (k >= 3 && k <= 5));
        end
      end
      checks++;
      if ({input_2, rise_2, fall_2} !== 3'b000) begin
        errors++;
        $display("FAIL clean_chan2_quiet E+%0d: got %b want 000", k - 1, {input_2, rise_2, fall_2});
      end
    end
  endtask

  task automatic test_bounce_reject();
    int busy_cycles;
    busy_cycles = 0;
    // input_1 is high from the previous scenario.
    for (int iter = 0; iter < 3; iter++) begin
      for (int k = 0; k < 5; k++) begin
        raw_1 = (k >= 2);
        step();
        if (busy === 1'b1) busy_cycles++;
        checks++;
        if (input_1 !== 1'b1 || fall_1 !== 1'b0) begin
          errors++;
          $display("FAIL bounce_hold iter %0d cyc %0d: got input_1=%b fall_1=%b want 1/0",
                   iter, k, input_1, fall_1);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      step();
      if (busy === 1'b1) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 6) begin
      errors++;
      $display("FAIL bounce_busy_cycles: got %0d want 6", busy_cycles);
    end
    checks++;
    if (input_1 !== 1'b1) begin
      errors++;
      $display("FAIL bounce_final_level: got %b want 1", input_1);
    end
  endtask

  task automatic test_both_channels();
    apply_reset();
    raw_1 = 1'b1;
    raw_2 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 3) raw_2 = 1'b0;
      checks++;
      if (input_1 !== (k >= 6) || rise_1 !== (k == 6)) begin
        errors++;
        $display("FAIL dual_chan1 E+%0d: got input_1=%b rise_1=%b want %b/%b",
                 k - 1, input_1, rise_1, (k >= 6), (k == 6));
      end
      checks++;
      if (input_2 !== 1'b0 || rise_2 !== 1'b0 || fall_2 !== 1'b0) begin
        errors++;
        $display("FAIL dual_chan2 E+%0d: got input_2=%b rise_2=%b fall_2=%b want 0/0/0",
                 k - 1, input_2, rise_2, fall_2);
      end
    end
  endtask

  task automatic test_reset_mid_check();
    apply_reset();
    raw_1 = 1'b1;
    for (int k = 1; k <= 4; k++) step();
    // Channel 1 now sits in CHECK_HIGH with count=2.
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midcheck_busy_before: got %b want 1", busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({input_1, busy, rise_1} !== 3'b000) begin
      errors++;
      $display("FAIL midcheck_after_rst: got input_1/busy/rise_1=%b want 000", {input_1, busy, rise_1});
    end
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (input_1 !== (k >= 6) || rise_1 !== (k == 6)) begin
        errors++;
        $display("FAIL midcheck_relatency E+%0d: got input_1=%b rise_1=%b want %b/%b",
                 k - 1, input_1, rise_1, (k >= 6), (k == 6));
      end
    end
  endtask

  task automatic test_full_cycle();
    int rise_cnt;
    int fall_cnt;
    int rise_at;
    int fall_at;
    rise_cnt = 0;
    fall_cnt = 0;
    rise_at  = -1;
    fall_at  = -1;
    apply_reset();
    raw_1 = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k == 10) raw_1 = 1'b0;
      if (rise_1 === 1'b1) begin rise_cnt++; rise_at = k; end
      if (fall_1 === 1'b1) begin fall_cnt++; fall_at = k; end
    end
    checks++;
    if (rise_cnt != 1) begin
      errors++;
      $display("FAIL cycle_rise_count: got %0d want 1", rise_cnt);
    end
    checks++;
    if (fall_cnt != 1) begin
      errors++;
      $display("FAIL cycle_fall_count: got %0d want 1", fall_cnt);
    end
    checks++;
    if (rise_at != 6) begin
      errors++;
      $display("FAIL cycle_rise_time: got step %0d want 6", rise_at);
    end
    checks++;
    if (fall_at - rise_at != 10) begin
      errors++;
      $display("FAIL cycle_separation: got %0d want 10", fall_at - rise_at);
    end
    checks++;
    if (input_1 !== 1'b0) begin
      errors++;
      $display("FAIL cycle_final_level: got %b want 0", input_1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    raw_1  = 1'b0;
    raw_2  = 1'b0;
    test_reset();
    test_clean_rise();
    test_bounce_reject();
    test_both_channels();
    test_reset_mid_check();
    test_full_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debounce_pair.md
Name: switch_debounce_pair

Overview:
- Two-channel switch/button conditioner that drives the input_1 and input_2 operands of the example AND gate from raw, bouncing board pins.
- Each channel synchronizes its asynchronous pin into the clock domain and filters it with a counter-based debounce state machine.
- Each channel produces a clean level plus single-cycle rise and fall strobes, so the AND stage and later logic only ever see glitch-free operands.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive clock edges the synchronized input must differ from the current output before the output follows (10 ms at 25 MHz). Legal range >= 1.
- SYNC_STAGES, 2: depth of the per-channel synchronizer flop chain. Legal range >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- raw_1  input  1  asynchronous switch pin, channel 1.
- raw_2  input  1  asynchronous switch pin, channel 2.
- input_1  output  1  debounced level, channel 1; feeds AND gate input_1.
- input_2  output  1  debounced level, channel 2; feeds AND gate input_2.
- rise_1  output  1  one-cycle strobe when input_1 goes 0->1.
- fall_1  output  1  one-cycle strobe when input_1 goes 1->0.
- rise_2  output  1  one-cycle strobe when input_2 goes 0->1.
- fall_2  output  1  one-cycle strobe when input_2 goes 1->0.
- busy  output  1  OR of both channels being in a CHECK state.

Behaviour:
- Reset (rst high at a rising clk edge):
  - All synchronizer flops, counters, input_x, rise_x, fall_x and busy become 0.
  - Both FSMs go to STABLE_LOW.
  - rst has priority over every other event, including mid-CHECK; no strobe is generated by reset.
- Synchronizer: raw_x passes through SYNC_STAGES flops; sync_x is the last stage. The two channels are fully independent and identical.
- Counter width is $clog2(DEBOUNCE_CYCLES+1).
- FSM per channel, 4 states:
  - STABLE_LOW: output 0. If sync_x=1, go to CHECK_HIGH with count=1; else stay.
  - CHECK_HIGH: output 0.
    - sync_x=0: return to STABLE_LOW, count=0 (bounce rejected).
    - sync_x=1 and count==DEBOUNCE_CYCLES-1: go to STABLE_HIGH, count=0, output becomes 1, rise_x=1 for that one cycle.
    - otherwise: count+1.
  - STABLE_HIGH and CHECK_LOW: mirror images of the above, producing fall_x.
  - DEBOUNCE_CYCLES=1: the transition from STABLE goes directly to the opposite STABLE on the first differing sync_x sample, skipping CHECK.
- All outputs are registered; input_x changes on the same edge its strobe asserts, and the strobe deasserts on the next edge.
- Latency: a clean raw edge that is sampled by synchronizer stage 1 at edge E produces the output change at edge E+SYNC_STAGES-1+DEBOUNCE_CYCLES. With defaults-for-test (4, 2) this is E+5.
- Any raw glitch shorter than DEBOUNCE_CYCLES synchronized samples never reaches the output.
- Simultaneous activity on both channels is processed independently, with no interaction or priority.
- The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
1. Hold rst=1 for 3 edges with raw_1=raw_2=1 -> all outputs 0 throughout reset; input_1 rises exactly 5 edges after rst deasserts (first sampling edge = E), with rise_1 high for that one cycle only.
2. raw_1 clean 0->1 sampled at edge E -> busy=1 from E+2; input_1=1 and rise_1=1 at E+5; rise_1=0 and busy=0 at E+6; input_2, rise_2 and fall_2 stay 0.
3. With input_1=1, toggle raw_1 low for 2 cycles, then high, repeating 3 times -> input_1 stays 1, fall_1 never asserts, busy pulses during each check.
4. raw_1 and raw_2 both go 1 at the same edge, then raw_2 returns low 3 edges later -> input_1 rises at E+5; input_2 never rises; no cross-channel effect.
5. raw_1 high and FSM in CHECK_HIGH with count=2, then assert rst for 1 edge -> input_1=0, busy=0, no rise_1 pulse; a fresh full 5-edge latency applies after reset releases.
6. Full cycle: raw_1 high for 10 cycles then low -> exactly one rise_1 and one fall_1 pulse, each exactly 1 cycle wide, separated by 10 edges.
